div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative multi-cycle divider for the M-extension DIV/DIVU/REM/REMU instructions in the pipelined RV32 core.
- Sits in the execute stage beside the ALU. Its `result` feeds the 4:1 result/writeback select mux alongside the ALU, memory and PC+4 paths.
- The hazard unit uses `busy` to stall the front of the pipeline while a division is in progress.
- Radix-2 restoring algorithm: one quotient bit per clock.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a new division; sampled only in IDLE or DONE.
- op  input  2  operation select, equal to funct3[1:0] (encoding in package).
- a  input  WIDTH  dividend (rs1).
- b  input  WIDTH  divisor (rs2).
- flush  input  1  synchronous abort of the current operation.
- busy  output  1  high while in BUSY state.
- done  output  1  one-cycle pulse: `result` is valid.
- result  output  WIDTH  quotient or remainder; held until the next completion.

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0, internal remainder/quotient=0. Reset mid-operation discards all work, with no done pulse.
- FSM states: IDLE, BUSY, DONE.
- IDLE or DONE, start=1 at edge E0, special case (b==0, or signed overflow a==0x80000000 with b==all-ones and op DIV/REM):
  - go to DONE and register the special result at E0.
  - done=1 in the cycle after E0 (latency 1).
- IDLE or DONE, start=1 at E0, normal case:
  - latch |a|, |b| (signed ops) or raw a, b (unsigned ops).
  - latch quotient-sign = sa^sb, remainder-sign = sa, and op.
  - load counter = WIDTH-1; go to BUSY.
- BUSY iteration, at each edge E1..E_WIDTH:
  - shift {rem, quo} left 1; trial = rem - divisor on WIDTH+1 bits.
  - if the trial is non-negative, rem=trial and the new quo bit is 1; otherwise the bit is 0.
  - decrement counter.
- BUSY completion, at the edge where counter==0:
  - apply sign fixup and register `result` (quotient for DIV/DIVU, remainder for REM/REMU).
  - go to DONE; done=1 in the following cycle.
  - normal latency: done visible WIDTH cycles after the start edge.
- DONE lasts exactly one cycle, then IDLE unless a new start is accepted. Back-to-back starts are allowed from DONE.
- start while BUSY is ignored; the operation in flight is unaffected.
- flush=1 in any state: next state IDLE, busy=0, done=0, `result` unchanged.
  - flush beats start in the same cycle.
  - flush beats completion in the same cycle: no done pulse.
- Special-case results (RISC-V spec):
  - b==0: DIV/DIVU return all-ones; REM/REMU return a.
  - overflow: DIV returns 0x80000000; REM returns 0.
- Sign fixup: quotient negated iff quotient-sign=1 (signed ops); remainder negated iff remainder-sign=1 (signed ops). Two's complement, modulo 2^WIDTH.
- Unsigned ops use no sign handling; |x| of 0x80000000 is 0x80000000 treated as unsigned.
- `busy` is a registered state decode: low in the special-case path and in DONE.

Decomposition:
- Shared package (core-wide definitions package):
  - op encodings: OP_DIV=2'b00, OP_DIVU=2'b01, OP_REM=2'b10, OP_REMU=2'b11.
  - FSM state encodings: S_IDLE, S_BUSY, S_DONE.
- One natural sub-module, div_step: combinational single restoring iteration.
  - inputs: rem, quo, divisor.
  - outputs: next rem, next quo.
- The top level holds the FSM, counter, operand capture and sign fixup.

Test Plan:
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy high 32 cycles; done pulse one cycle; result=0xFFFFFFFD (-3).
- REM a=-7, b=2 -> result=0xFFFFFFFF (-1). REMU a=7, b=3 -> result=1. DIVU a=0xFFFFFFFF, b=1 -> result=0xFFFFFFFF.
- DIVU a=100, b=0 -> busy never high; done in the next cycle; result=0xFFFFFFFF. REM a=100, b=0 -> result=100.
- Overflow case:
  - DIV a=0x80000000, b=0xFFFFFFFF -> 1-cycle done, result=0x80000000.
  - REM with the same operands -> result=0.
- Abort and ignored start:
  - start DIVU 1000/7, then assert start with other operands at cycle 5 -> ignored; final result=142.
  - repeat with flush at cycle 10 -> busy=0 next cycle; no done pulse; result keeps its prior value; a subsequent start computes correctly.
- Reset and back-to-back:
  - rst asserted mid-BUSY -> next cycle state IDLE, busy=0, done=0, result=0.
  - start held high in the DONE cycle -> second division accepted with no idle gap.

Source files
------------

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared op and FSM encodings for the M-extension divider
package div_unit_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // funct3[0] clear selects the signed flavour, funct3[1] set selects remainder
  function automatic logic op_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one radix-2 restoring division iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] trial;

  // rem < divisor always holds, so WIDTH+1 bits carry the trial sign unambiguously
  always_comb begin
    trial = {rem, quo[WIDTH-1]} - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
    end else begin
      rem_next = {rem[WIDTH-2:0], quo[WIDTH-1]};
    end
    quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative DIV/DIVU/REM/REMU unit for the execute stage
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, divisor, result_q;
  logic [1:0]       op_q;
  logic             q_neg, r_neg;

  logic             signed_op, a_neg, b_neg, b_zero, ovf, special, accept;
  logic [WIDTH-1:0] a_abs, b_abs, special_res;
  logic [WIDTH-1:0] rem_next, quo_next, fix_quo, fix_rem, final_res;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_comb begin
    signed_op = op_signed(op);
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_abs     = a_neg ? (~a + ONE) : a;
    b_abs     = b_neg ? (~b + ONE) : b;
    b_zero    = (b == '0);
    ovf       = signed_op & (a == INT_MIN) & (&b);
    special   = b_zero | ovf;
    if (b_zero) begin
      special_res = op_rem(op) ? a : '1;
    end else begin
      special_res = op_rem(op) ? '0 : a;
    end
    accept = start & (state != S_BUSY) & ~flush;
  end

  // Fixup is applied to the final iteration's outputs so completion costs no extra cycle
  always_comb begin
    fix_quo   = q_neg ? (~quo_next + ONE) : quo_next;
    fix_rem   = r_neg ? (~rem_next + ONE) : rem_next;
    final_res = op_rem(op_q) ? fix_rem : fix_quo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = special ? S_DONE : S_BUSY;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_BUSY: begin
        if (count == '0) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (flush) begin
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      op_q     <= OP_DIV;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_q <= '0;
    end else if (!flush) begin
      if (accept) begin
        if (special) begin
          result_q <= special_res;
        end else begin
          rem     <= '0;
          quo     <= a_abs;
          divisor <= b_abs;
          q_neg   <= a_neg ^ b_neg;
          r_neg   <= a_neg;
          op_q    <= op;
          count   <= CW'(WIDTH - 1);
        end
      end else if (state == S_BUSY) begin
        rem   <= rem_next;
        quo   <= quo_next;
        count <= count - CW'(1);
        if (count == '0) begin
          result_q <= final_res;
        end
      end
    end
  end

  assign busy   = (state == S_BUSY);
  assign done   = (state == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] result;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_count   = 0;
  logic [W-1:0] sb[$];

  div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic sgn, remop;
    sgn   = (o == OP_DIV) || (o == OP_REM);
    remop = (o == OP_REM) || (o == OP_REMU);
    if (y == '0) return remop ? x : '1;
    if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return remop ? '0 : x;
    if (sgn) return remop ? W'($signed(x) % $signed(y)) : W'($signed(x) / $signed(y));
    return remop ? (x % y) : (x / y);
  endfunction

  always @(negedge clk) begin
    if (done) begin
      done_count++;
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else chk("result", result, sb.pop_front());
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  // Called at a negedge; leaves at the negedge where done is seen so the next call is back-to-back
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n, busy_n;
    logic spec;
    spec = (y == '0) || (((o == OP_DIV) || (o == OP_REM)) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    sb.push_back(model(o, x, y));
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", W'(busy), spec ? 0 : 1);
    n = 0; busy_n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
      if (done) break;
    end
    chk("latency", W'(n), spec ? 1 : W + 1);
    chk("busy_cycles", W'(busy_n), spec ? 0 : W);
  endtask

  initial begin
    int n, dc;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = OP_DIV; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", W'(busy), 0);
    chk("reset_done", W'(done), 0);
    chk("reset_result", result, 0);
    @(negedge clk); rst = 1'b0;

    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk);
    chk("done_pulse", W'(done), 0);

    do_op(OP_REM,  32'hFFFF_FFF9, 32'd2);
    do_op(OP_REMU, 32'd7,         32'd3);
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1);
    do_op(OP_DIVU, 32'd100,       32'd0);
    do_op(OP_REM,  32'd100,       32'd0);
    do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    do_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    do_op(OP_DIV,  32'd7,         32'hFFFF_FFFF);
    do_op(OP_REM,  32'd7,         32'hFFFF_FFFE);
    do_op(OP_DIVU, 32'h8000_0000, 32'd3);
    do_op(OP_REM,  32'h8000_0000, 32'd7);
    do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      do_op(2'($urandom_range(0, 3)), $urandom, (i % 3 == 0) ? W'($urandom_range(1, 20)) : $urandom);
    end

    // start while busy is ignored
    @(negedge clk);
    sb.push_back(32'd142);
    op = OP_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    op = OP_DIV; a = 32'd50; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    repeat (40) @(negedge clk);
    chk("ignored_start_sb_empty", W'(sb.size()), 0);

    // flush mid-operation
    dc = done_count;
    op = OP_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_busy", W'(busy), 0);
    chk("flush_done", W'(done), 0);
    chk("flush_result_kept", result, 32'd142);
    @(negedge clk); flush = 1'b0;
    repeat (40) @(negedge clk);
    chk("flush_no_done", W'(done_count), W'(dc));
    do_op(OP_REMU, 32'd1000, 32'd7);

    // flush on the completion edge suppresses done and the result update
    @(negedge clk);
    dc = done_count;
    op = OP_DIV; a = 32'd100; b = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_at_end_done", W'(done), 0);
    chk("flush_at_end_result", result, 32'd6);
    @(negedge clk); flush = 1'b0;

    // flush beats start in the same cycle
    start = 1'b1; flush = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_vs_start_busy", W'(busy), 0);
    chk("flush_vs_start_done", W'(done), 0);
    repeat (5) @(negedge clk);
    chk("flush_sequences_no_done", W'(done_count), W'(dc));

    // reset mid-operation
    op = OP_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", W'(busy), 0);
    chk("midrst_done", W'(done), 0);
    chk("midrst_result", result, 0);
    @(negedge clk); rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", W'(done_count), W'(dc));
    do_op(OP_DIV, 32'hFFFF_FF9C, 32'd7);

    @(negedge clk);
    chk("sb_empty", W'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
